// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: in-order instruction prefetcher with a credit-limited FIFO.
// Redirects flush the FIFO and drop responses to fetches issued before them.
module ifetch_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins_out,
   output logic [31:0] ins_pc,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0]   cnt_t;
   typedef logic [AW-1:0] ptr_t;
   logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   cnt_t        count_q, count_d, pending_q, pending_d, discard_q, discard_d;
   ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [63:0] mem_q [DEPTH];
   logic [63:0] mem_d [DEPTH];
   logic        err_q, err_d;
   logic        req_fire, rsp_fire, push, pop;
   logic [AW+1:0] credit_used;
   // Every slot is either occupied or reserved by an in-flight fetch, so pushes never overflow.
   assign credit_used    = {1'b0, count_q} + {1'b0, pending_q};
   assign imem_req_valid = rst && !redirect_valid && (credit_used < (AW+2)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign ins_valid      = count_q != '0;
   assign ins_out        = ins_valid ? mem_q[rd_ptr_q][63:32] : '0;
   assign ins_pc         = ins_valid ? mem_q[rd_ptr_q][31:0] : '0;
   assign err            = err_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_fire       = imem_rsp_valid && pending_q != '0;
   assign push           = rsp_fire && !redirect_valid && discard_q == '0;
   assign pop            = ins_valid && ins_ready && !redirect_valid;
   always_comb begin
      fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
      rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
      pending_d  = pending_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
      discard_d  = (rsp_fire && discard_q != '0) ? discard_q - cnt_t'(1) : discard_q;
      count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
      rd_ptr_d   = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      wr_ptr_d   = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      err_d      = err_q || (imem_rsp_valid && pending_q == '0);
      mem_d      = mem_q;
      if (push) mem_d[wr_ptr_q] = {imem_rsp_data, rsp_pc_q};
      // Everything still outstanding after this cycle belongs to the old path.
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rsp_pc_d   = {redirect_pc[31:2], 2'b00};
         discard_d  = pending_q - cnt_t'(rsp_fire);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         pending_q  <= '0;
         discard_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         err_q      <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: directed bench with a fixed-latency memory returning addr ^ 32'hA5A5_0000.
module tb_ifetch_prefetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ins_valid, ins_ready;
   logic [31:0] ins_out, ins_pc;
   logic        err;
   int          vecs = 0, fails = 0, cyc = 0, lat = 1, n_req = 0;
   logic [31:0] q_addr[$];
   int          q_due[$];

   ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out), .ins_pc(ins_pc),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered and left mid-cycle on the falling edge.
   task automatic tick();
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = q_addr.pop_front() ^ 32'hA5A5_0000;
         void'(q_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         q_addr.push_back(imem_req_addr);
         q_due.push_back(cyc + lat);
         n_req++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      ins_ready = 1'b0;
      q_addr.delete();
      q_due.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      n_req = 0;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      ins_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, 0);
      chk("rst_ins_valid", ins_valid, 0);
      chk("rst_ins_out", ins_out, 0);
      chk("rst_ins_pc", ins_pc, 0);
      chk("rst_err", err, 0);
      // Streaming with a 1-cycle memory
      do_reset();
      imem_req_ready = 1'b1;
      ins_ready = 1'b1;
      lat = 1;
      chk("s_valid0", imem_req_valid, 1);
      chk("s_addr0", imem_req_addr, 32'h0);
      tick();
      chk("s_addr1", imem_req_addr, 32'h4);
      chk("s_empty1", ins_valid, 0);
      tick();
      chk("s_ins_valid2", ins_valid, 1);
      chk("s_pc2", ins_pc, 32'h0);
      chk("s_out2", ins_out, 32'hA5A5_0000);
      chk("s_addr2", imem_req_addr, 32'h8);
      tick();
      chk("s_pc3", ins_pc, 32'h4);
      chk("s_out3", ins_out, 32'hA5A5_0004);
      tick();
      chk("s_pc4", ins_pc, 32'h8);
      chk("s_out4", ins_out, 32'hA5A5_0008);
      chk("s_err", err, 0);
      // Consumer stalled: credits cap issue at DEPTH
      do_reset();
      imem_req_ready = 1'b1;
      lat = 1;
      repeat (20) tick();
      chk("bp_nreq", n_req, 4);
      chk("bp_req_valid", imem_req_valid, 0);
      chk("bp_pc0", ins_pc, 32'h0);
      ins_ready = 1'b1;
      tick();
      chk("bp_pc4", ins_pc, 32'h4);
      chk("bp_resume_valid", imem_req_valid, 1);
      chk("bp_resume_addr", imem_req_addr, 32'h10);
      tick();
      chk("bp_pc8", ins_pc, 32'h8);
      tick();
      chk("bp_pcC", ins_pc, 32'hC);
      tick();
      chk("bp_pc10", ins_pc, 32'h10);
      chk("bp_out10", ins_out, 32'hA5A5_0010);
      // Redirect with 3-cycle memory and 3 fetches pending
      do_reset();
      imem_req_ready = 1'b1;
      lat = 3;
      repeat (4) tick();
      chk("rd_pre_valid", ins_valid, 1);
      chk("rd_pre_pc", ins_pc, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      chk("rd_no_req", imem_req_valid, 0);
      tick();
      chk("rd_flushed", ins_valid, 0);
      chk("rd_new_addr", imem_req_addr, 32'h100);
      chk("rd_new_valid", imem_req_valid, 1);
      tick();
      chk("rd_drop2", ins_valid, 0);
      tick();
      chk("rd_drop3", ins_valid, 0);
      tick();
      chk("rd_wait", ins_valid, 0);
      tick();
      chk("rd_first_pc", ins_pc, 32'h100);
      chk("rd_first_out", ins_out, 32'hA5A5_0100);
      // Redirect coinciding with a response and a pop
      ins_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0202;
      tick();
      chk("rc_flushed", ins_valid, 0);
      chk("rc_addr", imem_req_addr, 32'h200);
      tick();
      chk("rc_drop1", ins_valid, 0);
      tick();
      chk("rc_drop2", ins_valid, 0);
      tick();
      chk("rc_wait", ins_valid, 0);
      tick();
      chk("rc_first_pc", ins_pc, 32'h200);
      chk("rc_first_out", ins_out, 32'hA5A5_0200);
      // Memory not ready: request held stable
      do_reset();
      imem_req_ready = 1'b1;
      ins_ready = 1'b1;
      lat = 1;
      repeat (2) tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("st_addr_held", imem_req_addr, 32'h8);
         chk("st_valid_held", imem_req_valid, 1);
         tick();
      end
      chk("st_nreq", n_req, 2);
      chk("st_drained", ins_valid, 0);
      imem_req_ready = 1'b1;
      tick();
      tick();
      chk("st_pc8", ins_pc, 32'h8);
      chk("st_out8", ins_out, 32'hA5A5_0008);
      // Spurious response sets sticky err
      imem_req_ready = 1'b0;
      repeat (3) tick();
      chk("er_idle", ins_valid, 0);
      chk("er_clear", err, 0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      #1;
      chk("er_set", err, 1);
      chk("er_fifo", ins_valid, 0);
      tick();
      chk("er_sticky", err, 1);
      rst = 1'b0;
      #1;
      chk("er_async_clr", err, 0);
      chk("er_rst_req", imem_req_valid, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
